// File: rtl/weight_pingpong_buf_if.sv
// Bus bundle for the ping-pong weight buffer: configuration, write handshake,
// swap handshake and read port. The master side drives beats, swaps and reads.
interface weight_pingpong_buf_if #(
  parameter int IN_W  = 128,
  parameter int OUT_W = 160,
  parameter int SEL_W = 4,
  parameter int CNT_W = 2
);
  logic [CNT_W-1:0] cfg_wr_cnt;
  logic [1:0]       cfg_mode;
  logic             wr_vld;
  logic             wr_rdy;
  logic [IN_W-1:0]  wr_data;
  logic             wr_done;
  logic             swap_req;
  logic             swap_ack;
  logic             rd_en;
  logic [SEL_W-1:0] rd_sel;
  logic [OUT_W-1:0] rd_data;
  logic             rd_vld;
  logic             rd_err;
  logic             act_vld;

  modport master (
    output cfg_wr_cnt, cfg_mode, wr_vld, wr_data, swap_req, rd_en, rd_sel,
    input  wr_rdy, wr_done, swap_ack, rd_data, rd_vld, rd_err, act_vld
  );

  modport slave (
    input  cfg_wr_cnt, cfg_mode, wr_vld, wr_data, swap_req, rd_en, rd_sel,
    output wr_rdy, wr_done, swap_ack, rd_data, rd_vld, rd_err, act_vld
  );
endinterface

// File: rtl/weight_pingpong_buf.sv
// Double-buffered weight register. The shadow bank is filled beat by beat
// while the routing array reads the active bank; a swap request promotes the
// shadow bank once it is full, waiting (pending) if the fill is incomplete.
module weight_pingpong_buf #(
  parameter int IN_W       = 128,
  parameter int WORDS      = 4,
  parameter int SLICE_W    = 40,
  parameter int OUT_SLICES = 4,
  parameter int SEL_W      = 4,
  parameter int CNT_W      = (WORDS > 1) ? $clog2(WORDS) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  weight_pingpong_buf_if.slave   bus
);

  localparam int REG_W   = IN_W * WORDS;
  localparam int OUT_W   = SLICE_W * OUT_SLICES;
  localparam int HALF    = OUT_SLICES / 2;
  localparam int N_DENSE = REG_W / OUT_W;
  localparam int N_SLICE = REG_W / SLICE_W;
  localparam int N_PAIR  = REG_W / (2 * SLICE_W);

  // Per-bank lifecycle; the active bank is parked in ST_ACTIVE.
  typedef enum logic [1:0] {
    ST_EMPTY  = 2'd0,
    ST_FILL   = 2'd1,
    ST_FULL   = 2'd2,
    ST_ACTIVE = 2'd3
  } bank_state_t;

  // Bank storage (not reset: contents are only meaningful once filled)
  logic [REG_W-1:0] bank_mem [2];

  bank_state_t      bank_state_reg [2];
  logic             act_bank_reg;
  logic             act_vld_reg;
  logic [CNT_W-1:0] wptr_reg;
  logic [CNT_W-1:0] cnt_lat_reg;
  logic             swap_pend_reg;
  logic             wr_done_reg;
  logic             swap_ack_reg;

  logic [OUT_W-1:0] rd_data_reg;
  logic             rd_vld_reg;
  logic             rd_err_reg;

  logic             shadow_bank;
  logic             shadow_full;
  logic             wr_rdy;
  logic             beat_fire;
  logic [CNT_W-1:0] cur_cnt;
  logic             last_fire;
  logic             swap_fire;

  assign shadow_bank = ~act_bank_reg;
  assign shadow_full = (bank_state_reg[shadow_bank] == ST_FULL);
  assign wr_rdy      = ~shadow_full;
  assign beat_fire   = bus.wr_vld & wr_rdy;
  // The beat count is taken live on the first beat, latched for the rest.
  assign cur_cnt     = (wptr_reg == '0) ? bus.cfg_wr_cnt : cnt_lat_reg;
  assign last_fire   = beat_fire & (wptr_reg == cur_cnt);
  assign swap_fire   = (bus.swap_req | swap_pend_reg) & (shadow_full | last_fire);

  // Beat write into the shadow bank; untouched beats keep old contents
  always_ff @(posedge clk) begin
    if (!rst && beat_fire) begin
      bank_mem[shadow_bank][wptr_reg*IN_W +: IN_W] <= bus.wr_data;
    end
  end

  // Fill/swap control FSM with registered done/ack pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      bank_state_reg[0] <= ST_ACTIVE;
      bank_state_reg[1] <= ST_EMPTY;
      act_bank_reg      <= 1'b0;
      act_vld_reg       <= 1'b0;
      wptr_reg          <= '0;
      cnt_lat_reg       <= '0;
      swap_pend_reg     <= 1'b0;
      wr_done_reg       <= 1'b0;
      swap_ack_reg      <= 1'b0;
    end else begin
      wr_done_reg  <= last_fire;
      swap_ack_reg <= swap_fire;

      if (beat_fire) begin
        if (wptr_reg == '0) begin
          cnt_lat_reg <= bus.cfg_wr_cnt;
        end
        if (last_fire) begin
          wptr_reg                    <= '0;
          bank_state_reg[shadow_bank] <= ST_FULL;
        end else begin
          wptr_reg                    <= wptr_reg + CNT_W'(1);
          bank_state_reg[shadow_bank] <= ST_FILL;
        end
      end

      // A swap on the last-beat edge overrides the FULL transition above:
      // the just-completed bank goes straight to active.
      if (swap_fire) begin
        act_bank_reg                 <= shadow_bank;
        act_vld_reg                  <= 1'b1;
        bank_state_reg[shadow_bank]  <= ST_ACTIVE;
        bank_state_reg[act_bank_reg] <= ST_EMPTY;
        wptr_reg                     <= '0;
        swap_pend_reg                <= 1'b0;
      end else if (bus.swap_req) begin
        swap_pend_reg <= 1'b1;
      end
    end
  end

  // Views of the active bank: dense words, single slices, slice pairs
  logic [SLICE_W-1:0] slice_arr [N_SLICE];
  logic [OUT_W-1:0]   dense_arr [N_DENSE];
  logic [OUT_W-1:0]   bcast_arr [N_SLICE];
  logic [OUT_W-1:0]   pair_arr  [N_PAIR];

  genvar gi;
  generate
    for (gi = 0; gi < N_SLICE; gi++) begin : g_slice
      assign slice_arr[gi] = bank_mem[act_bank_reg][gi*SLICE_W +: SLICE_W];
      assign bcast_arr[gi] = {OUT_SLICES{slice_arr[gi]}};
    end
    for (gi = 0; gi < N_DENSE; gi++) begin : g_dense
      assign dense_arr[gi] = bank_mem[act_bank_reg][gi*OUT_W +: OUT_W];
    end
    for (gi = 0; gi < N_PAIR; gi++) begin : g_pair
      assign pair_arr[gi] = {{HALF{slice_arr[2*gi+1]}}, {HALF{slice_arr[2*gi]}}};
    end
  endgenerate

  logic [OUT_W-1:0] rd_data_next;
  logic             rd_in_range;

  // Read-mode mux; an index with no matching entry stays out of range
  always_comb begin
    rd_data_next = '0;
    rd_in_range  = 1'b0;
    case (bus.cfg_mode)
      2'b00: begin
        for (int i = 0; i < N_DENSE; i++) begin
          if (int'(bus.rd_sel) == i) begin
            rd_data_next = dense_arr[i];
            rd_in_range  = 1'b1;
          end
        end
      end
      2'b01: begin
        for (int i = 0; i < N_SLICE; i++) begin
          if (int'(bus.rd_sel) == i) begin
            rd_data_next = bcast_arr[i];
            rd_in_range  = 1'b1;
          end
        end
      end
      2'b10: begin
        for (int i = 0; i < N_PAIR; i++) begin
          if (int'(bus.rd_sel) == i) begin
            rd_data_next = pair_arr[i];
            rd_in_range  = 1'b1;
          end
        end
      end
      default: begin
        rd_data_next = '0;
        rd_in_range  = 1'b0;
      end
    endcase
  end

  // Registered read port; data holds while idle, zero on a rejected read
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_reg <= '0;
      rd_vld_reg  <= 1'b0;
      rd_err_reg  <= 1'b0;
    end else if (bus.rd_en) begin
      if (act_vld_reg && rd_in_range) begin
        rd_data_reg <= rd_data_next;
        rd_vld_reg  <= 1'b1;
        rd_err_reg  <= 1'b0;
      end else begin
        rd_data_reg <= '0;
        rd_vld_reg  <= 1'b0;
        rd_err_reg  <= 1'b1;
      end
    end else begin
      rd_vld_reg <= 1'b0;
      rd_err_reg <= 1'b0;
    end
  end

  assign bus.wr_rdy   = wr_rdy;
  assign bus.wr_done  = wr_done_reg;
  assign bus.swap_ack = swap_ack_reg;
  assign bus.rd_data  = rd_data_reg;
  assign bus.rd_vld   = rd_vld_reg;
  assign bus.rd_err   = rd_err_reg;
  assign bus.act_vld  = act_vld_reg;

endmodule
